mips_instr_encoder: RTL and testbench

- Instruction encoder and loader for the single-cycle MIPS core; the producing end of the opcode/funct interface that the core's control decoder consumes.
- Accepts instruction descriptors (class index plus register, shift, immediate and target fields) over a valid/ready handshake.
- Packs each descriptor into a 32-bit MIPS word and buffers it in a small FIFO.
- Streams the buffered words into instruction memory at consecutive word addresses through a stallable write port.

---
 rtl/mips_instr_encoder.sv | 164 ++++++++++++++++
 tb/tb_mips_instr_encoder.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// Packs MIPS instruction descriptors into 32-bit words, buffers them in a FIFO and
// streams them into instruction memory at consecutive word addresses.
module mips_instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_class,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        im_we,
    input  logic        im_ready,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic [15:0] word_cnt,
    output logic        err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {KindR, KindI, KindJ} kind_e;

    logic [AW:0]   count_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   addr_q;
    logic [15:0]   word_cnt_q;
    logic          err_q;
    logic          ready_en_q;

    logic          fifo_full, fifo_empty;
    logic          accept, push, pop;

    kind_e         kind;
    logic          enc_legal;
    logic [5:0]    op, funct;
    logic [4:0]    rs, rt, rd, sh;
    logic [31:0]   enc_word;

    always_comb begin
        kind      = KindR;
        enc_legal = 1'b1;
        op        = 6'b000000;
        funct     = 6'b000000;
        rs        = in_rs;
        rt        = in_rt;
        rd        = in_rd;
        sh        = in_shamt;
        case (in_class)
            5'd0:  funct = 6'b100000;
            5'd1:  funct = 6'b100010;
            5'd2:  funct = 6'b100001;
            5'd3:  funct = 6'b100011;
            5'd4:  funct = 6'b100100;
            5'd5:  funct = 6'b100101;
            5'd6:  funct = 6'b000000;
            5'd7:  funct = 6'b000010;
            5'd8:  funct = 6'b000011;
            5'd9:  funct = 6'b101010;
            5'd10: funct = 6'b001000;
            5'd11: begin kind = KindI; op = 6'b100011; end
            5'd12: begin kind = KindI; op = 6'b101011; end
            5'd13: begin kind = KindI; op = 6'b001101; end
            5'd14: begin kind = KindI; op = 6'b000100; end
            5'd15: begin kind = KindI; op = 6'b000101; end
            5'd16: begin kind = KindI; op = 6'b001111; end
            5'd17: begin kind = KindI; op = 6'b001000; end
            5'd18: begin kind = KindI; op = 6'b001010; end
            5'd19: begin kind = KindJ; op = 6'b000010; end
            5'd20: begin kind = KindJ; op = 6'b000011; end
            default: enc_legal = 1'b0;
        endcase

        // Shifts take their operand from rt, so rs is unused; other R-types ignore shamt.
        if (in_class >= 5'd6 && in_class <= 5'd8) begin
            rs = 5'd0;
        end else if (kind == KindR) begin
            sh = 5'd0;
        end
        if (in_class == 5'd10) begin
            rt = 5'd0;
            rd = 5'd0;
        end
        if (in_class == 5'd16) begin
            rs = 5'd0;
        end

        case (kind)
            KindI:   enc_word = {op, rs, rt, in_imm};
            KindJ:   enc_word = {op, in_target};
            default: enc_word = {6'b000000, rs, rt, rd, sh, funct};
        endcase
    end

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    assign in_ready = ready_en_q && !fifo_full && !start;
    assign accept   = in_valid && in_ready;
    assign push     = accept && enc_legal;
    assign pop      = im_we && im_ready && !start;

    assign im_we    = !fifo_empty;
    assign im_wdata = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
    assign im_addr  = addr_q;
    assign word_cnt = word_cnt_q;
    assign err      = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready_en_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            addr_q     <= BASE_ADDR;
            word_cnt_q <= 16'd0;
            err_q      <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (start) begin
                count_q    <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                addr_q     <= BASE_ADDR;
                word_cnt_q <= 16'd0;
                err_q      <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q   <= rd_ptr_q + 1'b1;
                    addr_q     <= addr_q + 32'd4;
                    word_cnt_q <= word_cnt_q + 16'd1;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
                if (accept && !enc_legal) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder: encodings, FIFO back-pressure, start flush,
// illegal classes and reset behaviour, with memory writes captured into a queue.
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_class = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_shamt = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        im_we;
    logic        im_ready = 1'b0;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic [15:0] word_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    mips_instr_encoder #(
        .DEPTH(4),
        .BASE_ADDR(32'h0000_3000)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_class(in_class),
        .in_rs(in_rs),
        .in_rt(in_rt),
        .in_rd(in_rd),
        .in_shamt(in_shamt),
        .in_imm(in_imm),
        .in_target(in_target),
        .im_we(im_we),
        .im_ready(im_ready),
        .im_addr(im_addr),
        .im_wdata(im_wdata),
        .word_cnt(word_cnt),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rstn && im_we && im_ready && !start) begin
            wr_addr_q.push_back(im_addr);
            wr_data_q.push_back(im_wdata);
        end
    end

    task automatic drive(input logic [4:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                         input logic [25:0] tgt);
        bit ok = 0;
        @(negedge clk);
        in_class = c; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_imm = imm; in_target = tgt; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL drive_accept: in_ready=%b required 1 within 40 cycles", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 50; i++) begin
            if (wr_data_q.size() >= n) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wr_data_q.size() != n) begin
            errors++;
            $display("FAIL write_count: got %0d writes required %0d", wr_data_q.size(), n);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL start_in_ready: in_ready=%b required 0", in_ready);
        end
        @(posedge clk);
        #1 start = 1'b0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_reset();
        im_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({im_we, in_ready, err} !== 3'b000 || im_wdata !== 32'h0 || im_addr !== 32'h3000
            || word_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: we=%b rdy=%b err=%b wdata=%h addr=%h cnt=%0d required 0 0 0 0 3000 0",
                     im_we, in_ready, err, im_wdata, im_addr, word_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_release_ready: in_ready=%b required 0", in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_add();
        im_ready = 1'b1;
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        checks++;
        if (im_we !== 1'b1 || im_wdata !== 32'h0022_1820 || im_addr !== 32'h3000) begin
            errors++;
            $display("FAIL add_latency: we=%b wdata=%h addr=%h required 1 00221820 00003000",
                     im_we, im_wdata, im_addr);
        end
        wait_writes(1);
        checks++;
        if (word_cnt !== 16'd1 || im_we !== 1'b0) begin
            errors++;
            $display("FAIL add_count: cnt=%0d we=%b required 1 0", word_cnt, im_we);
        end
    endtask

    task automatic test_lw_jal();
        pulse_start();
        im_ready = 1'b1;
        drive(5'd11, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
        drive(5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0000);
        wait_writes(2);
        checks++;
        if (wr_data_q.size() != 2 || wr_data_q[0] !== 32'h8FA8_0004 || wr_addr_q[0] !== 32'h3000
            || wr_data_q[1] !== 32'h0C10_0000 || wr_addr_q[1] !== 32'h3004) begin
            errors++;
            $display("FAIL lw_jal: got %p @ %p required 8fa80004@3000 0c100000@3004",
                     wr_data_q, wr_addr_q);
        end
    endtask

    task automatic test_lui_sll();
        pulse_start();
        im_ready = 1'b1;
        drive(5'd16, 5'd5, 5'd1, 5'd0, 5'd0, 16'h1234, 26'h0);
        drive(5'd6, 5'd7, 5'd3, 5'd2, 5'd4, 16'h0, 26'h0);
        wait_writes(2);
        checks++;
        if (wr_data_q.size() != 2 || wr_data_q[0] !== 32'h3C01_1234
            || wr_data_q[1] !== 32'h0003_1100) begin
            errors++;
            $display("FAIL lui_sll: got %p required 3c011234 00031100", wr_data_q);
        end
    endtask

    task automatic test_encodings();
        logic [4:0]  cls [6] = '{5'd10, 5'd1, 5'd14, 5'd13, 5'd19, 5'd8};
        logic [4:0]  f_rs [6] = '{5'd31, 5'd1, 5'd4, 5'd2, 5'd0, 5'd9};
        logic [4:0]  f_rt [6] = '{5'd5, 5'd2, 5'd5, 5'd3, 5'd0, 5'd4};
        logic [4:0]  f_rd [6] = '{5'd6, 5'd3, 5'd0, 5'd0, 5'd0, 5'd5};
        logic [4:0]  f_sh [6] = '{5'd7, 5'd5, 5'd0, 5'd0, 5'd0, 5'd31};
        logic [15:0] f_imm [6] = '{16'h0, 16'h0, 16'hFFFF, 16'h00FF, 16'h0, 16'h0};
        logic [25:0] f_tgt [6] = '{26'h0, 26'h0, 26'h0, 26'h0, 26'h3FF_FFFF, 26'h0};
        logic [31:0] exp [6] = '{32'h03E0_0008, 32'h0022_1822, 32'h1085_FFFF,
                                 32'h3443_00FF, 32'h0BFF_FFFF, 32'h0004_2FC3};
        pulse_start();
        im_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(cls[i], f_rs[i], f_rt[i], f_rd[i], f_sh[i], f_imm[i], f_tgt[i]);
        end
        wait_writes(6);
        for (int i = 0; i < 6 && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_data_q[i] !== exp[i] || wr_addr_q[i] !== 32'h3000 + 32'(4 * i)) begin
                errors++;
                $display("FAIL encode_class%0d: got %h@%h required %h@%h", cls[i], wr_data_q[i],
                         wr_addr_q[i], exp[i], 32'h3000 + 32'(4 * i));
            end
        end
        checks++;
        if (word_cnt !== 16'd6) begin
            errors++; $display("FAIL encode_count: cnt=%0d required 6", word_cnt);
        end
    endtask

    task automatic test_back_pressure();
        pulse_start();
        im_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 16'(i), 26'h0);
        end
        @(negedge clk);
        in_class = 5'd17; in_rs = '0; in_rt = '0; in_imm = 16'd4; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || im_we !== 1'b1 || im_wdata !== 32'h2000_0000
            || im_addr !== 32'h3000) begin
            errors++;
            $display("FAIL full_stall: rdy=%b we=%b wdata=%h addr=%h required 0 1 20000000 3000",
                     in_ready, im_we, im_wdata, im_addr);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || im_wdata !== 32'h2000_0000 || im_addr !== 32'h3000
            || word_cnt !== 16'd0) begin
            errors++;
            $display("FAIL stall_stable: rdy=%b wdata=%h addr=%h cnt=%0d required 0 20000000 3000 0",
                     in_ready, im_wdata, im_addr, word_cnt);
        end
        in_valid = 1'b0;
        im_ready = 1'b1;
        drive(5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 16'd4, 26'h0);
        wait_writes(5);
        for (int i = 0; i < 5 && i < wr_data_q.size(); i++) begin
            checks++;
            if (wr_data_q[i] !== 32'h2000_0000 + 32'(i) || wr_addr_q[i] !== 32'h3000 + 32'(4 * i))
            begin
                errors++;
                $display("FAIL drain_%0d: got %h@%h required %h@%h", i, wr_data_q[i], wr_addr_q[i],
                         32'h2000_0000 + 32'(i), 32'h3000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_illegal();
        pulse_start();
        im_ready = 1'b1;
        drive(5'd25, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (err !== 1'b1 || im_we !== 1'b0 || wr_data_q.size() != 0 || word_cnt !== 16'd0) begin
            errors++;
            $display("FAIL illegal: err=%b we=%b writes=%0d cnt=%0d required 1 0 0 0",
                     err, im_we, wr_data_q.size(), word_cnt);
        end
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        wait_writes(1);
        checks++;
        if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'h0022_1820 || wr_addr_q[0] !== 32'h3000
            || err !== 1'b1) begin
            errors++;
            $display("FAIL after_illegal: got %p @ %p err=%b required 00221820@3000 err=1",
                     wr_data_q, wr_addr_q, err);
        end
        pulse_start();
        checks++;
        if (err !== 1'b0 || word_cnt !== 16'd0) begin
            errors++; $display("FAIL start_clear: err=%b cnt=%0d required 0 0", err, word_cnt);
        end
    endtask

    task automatic test_start_flush();
        pulse_start();
        im_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(5'd13, 5'd2, 5'd3, 5'd0, 5'd0, 16'(i), 26'h0);
        end
        checks++;
        if (im_we !== 1'b1) begin
            errors++; $display("FAIL queued: we=%b required 1", im_we);
        end
        pulse_start();
        checks++;
        if (im_we !== 1'b0 || im_addr !== 32'h3000 || word_cnt !== 16'd0) begin
            errors++;
            $display("FAIL flush: we=%b addr=%h cnt=%0d required 0 3000 0", im_we, im_addr, word_cnt);
        end
        drive(5'd16, 5'd0, 5'd7, 5'd0, 5'd0, 16'hBEEF, 26'h0);
        @(negedge clk);
        im_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (word_cnt !== 16'd0 || im_we !== 1'b0 || im_addr !== 32'h3000
            || wr_data_q.size() != 0) begin
            errors++;
            $display("FAIL start_vs_write: cnt=%0d we=%b addr=%h writes=%0d required 0 0 3000 0",
                     word_cnt, im_we, im_addr, wr_data_q.size());
        end
        drive(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        wait_writes(1);
        checks++;
        if (wr_data_q.size() != 1 || wr_addr_q[0] !== 32'h3000 || wr_data_q[0] !== 32'h0022_1820)
        begin
            errors++;
            $display("FAIL post_flush: got %p @ %p required 00221820@3000", wr_data_q, wr_addr_q);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        im_ready = 1'b0;
        drive(5'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'h10, 26'h0);
        drive(5'd12, 5'd1, 5'd3, 5'd0, 5'd0, 16'h14, 26'h0);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (im_we !== 1'b0 || in_ready !== 1'b0 || im_wdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: we=%b rdy=%b wdata=%h required 0 0 0",
                     im_we, in_ready, im_wdata);
        end
        @(negedge clk);
        rstn = 1'b1;
        im_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (im_we !== 1'b0 || word_cnt !== 16'd0 || wr_data_q.size() != 0 || in_ready !== 1'b1)
        begin
            errors++;
            $display("FAIL reset_discard: we=%b cnt=%0d writes=%0d rdy=%b required 0 0 0 1",
                     im_we, word_cnt, wr_data_q.size(), in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_jal();
        test_lui_sll();
        test_encodings();
        test_back_pressure();
        test_illegal();
        test_start_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
